// File: rtl/sbox_bram_table_loader.sv
// Loads a fresh masked S-box table into a dual-port BRAM two bytes per beat,
// then reads it back through both ports and compares rolling checksums.
module sbox_bram_table_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [15:0]       i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_bram_addra,
  output logic [ADDR_W-1:0] o_bram_addrb,
  output logic [7:0]        o_bram_dia,
  output logic [7:0]        o_bram_dib,
  output logic              o_bram_wea,
  output logic              o_bram_web,
  output logic              o_bram_en,
  input  logic [7:0]        i_doa,
  input  logic [7:0]        i_dob,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_check_ok,
  output logic [15:0]       o_checksum
);

  localparam int unsigned PTR_W = ADDR_W - 1;
  localparam int unsigned PAIRS = DEPTH / 2;
  localparam int unsigned CNT_W = ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [PTR_W-1:0]   r_samp_cnt;
  logic [RD_LAT-1:0]  r_vpipe;
  logic [7:0]         r_cs_a;
  logic [7:0]         r_cs_b;
  logic [7:0]         r_rd_a;
  logic [7:0]         r_rd_b;
  logic [15:0]        r_checksum;
  logic               r_check_ok;

  logic               w_beat;
  logic               w_last_beat;
  logic               w_issue;
  logic               w_sample;
  logic               w_last_sample;
  logic [7:0]         w_cs_a_nxt;
  logic [7:0]         w_cs_b_nxt;

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  assign w_cs_a_nxt    = rotl1(r_cs_a) ^ i_in_data[7:0];
  assign w_cs_b_nxt    = rotl1(r_cs_b) ^ i_in_data[15:8];
  assign w_last_beat   = w_beat && (r_ptr == PTR_W'(PAIRS - 1));
  assign w_sample      = r_vpipe[RD_LAT-1];
  assign w_last_sample = w_sample && (r_samp_cnt == PTR_W'(PAIRS - 1));
  assign o_check_ok    = r_check_ok;
  assign o_checksum    = r_checksum;

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and the BRAM-facing combinational outputs.
  always_comb begin
    w_state_nxt  = r_state;
    o_in_ready   = 1'b0;
    o_bram_wea   = 1'b0;
    o_bram_web   = 1'b0;
    o_bram_en    = 1'b0;
    o_bram_addra = '0;
    o_bram_addrb = '0;
    o_bram_dia   = '0;
    o_bram_dib   = '0;
    w_beat       = 1'b0;
    w_issue      = 1'b0;
    o_busy       = (r_state != S_IDLE);
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_in_ready   = 1'b1;
        w_beat       = i_in_valid;
        o_bram_addra = {r_ptr, 1'b0};
        o_bram_addrb = {r_ptr, 1'b1};
        if (w_beat) begin
          o_bram_wea = 1'b1;
          o_bram_web = 1'b1;
          o_bram_en  = 1'b1;
          o_bram_dia = i_in_data[7:0];
          o_bram_dib = i_in_data[15:8];
        end
        if (w_last_beat) w_state_nxt = S_VERIFY;
      end
      S_VERIFY: begin
        o_bram_en    = 1'b1;
        o_bram_addra = {r_ptr, 1'b0};
        o_bram_addrb = {r_ptr, 1'b1};
        w_issue      = (r_issue_cnt < CNT_W'(PAIRS));
        if (w_last_sample) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer, counters, read-valid pipe and both checksum accumulators.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr       <= '0;
      r_issue_cnt <= '0;
      r_samp_cnt  <= '0;
      r_vpipe     <= '0;
      r_cs_a      <= '0;
      r_cs_b      <= '0;
      r_rd_a      <= '0;
      r_rd_b      <= '0;
      r_checksum  <= '0;
      r_check_ok  <= 1'b0;
    end else begin
      r_vpipe <= (r_vpipe << 1) | RD_LAT'(w_issue);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ptr       <= '0;
            r_issue_cnt <= '0;
            r_samp_cnt  <= '0;
            r_cs_a      <= '0;
            r_cs_b      <= '0;
            r_rd_a      <= '0;
            r_rd_b      <= '0;
            r_check_ok  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            r_cs_a <= w_cs_a_nxt;
            r_cs_b <= w_cs_b_nxt;
            r_ptr  <= r_ptr + PTR_W'(1);
          end
          if (w_last_beat) r_checksum <= {w_cs_b_nxt, w_cs_a_nxt};
        end
        S_VERIFY: begin
          if (w_issue) begin
            r_ptr       <= r_ptr + PTR_W'(1);
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
          end
          if (w_sample) begin
            r_rd_a     <= rotl1(r_rd_a) ^ i_doa;
            r_rd_b     <= rotl1(r_rd_b) ^ i_dob;
            r_samp_cnt <= r_samp_cnt + PTR_W'(1);
          end
        end
        S_DONE: begin
          r_check_ok <= ({r_rd_b, r_rd_a} == {r_cs_b, r_cs_a});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_bram_table_loader.sv
// Randomized self-checking bench: drives tables into the loader, models the
// BRAM with two-cycle registered reads, and checks against a table-level model.
module tb_sbox_bram_table_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  addra, addrb;
  logic [7:0]  dia, dib;
  logic        wea, web, en;
  logic [7:0]  doa, dob;
  logic        busy, done, check_ok;
  logic [15:0] checksum;

  logic [7:0]  tbl [0:1023];
  logic [7:0]  mem [0:1023];
  logic [7:0]  rda1, rdb1;
  bit          flip37 = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  sbox_bram_table_loader #(.DEPTH(1024), .ADDR_W(10), .RD_LAT(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_data(in_data),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_bram_addra(addra), .o_bram_addrb(addrb),
    .o_bram_dia(dia), .o_bram_dib(dib),
    .o_bram_wea(wea), .o_bram_web(web), .o_bram_en(en),
    .i_doa(doa), .i_dob(dob),
    .o_busy(busy), .o_done(done), .o_check_ok(check_ok), .o_checksum(checksum)
  );

  // Ideal BRAM: write-first-free, two-cycle read with output register.
  always @(posedge clk) begin
    if (en) begin
      if (wea) mem[addra] <= dia;
      if (web) mem[addrb] <= dib;
      rda1 <= mem[addra] ^ ((flip37 && addra == 10'd37) ? 8'h01 : 8'h00);
      rdb1 <= mem[addrb] ^ ((flip37 && addrb == 10'd37) ? 8'h01 : 8'h00);
      doa  <= rda1;
      dob  <= rdb1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rolling rotate-left-by-one XOR checksum over the table, optionally with
  // bit 0 of address 37 flipped as the faulty BRAM would return it.
  function automatic logic [15:0] model_cs(input bit apply_flip);
    logic [7:0] ca, cb, a, b;
    ca = 8'h00;
    cb = 8'h00;
    for (int i = 0; i < 512; i++) begin
      a = tbl[2*i];
      b = tbl[2*i+1];
      if (apply_flip && (2*i) == 37)   a = a ^ 8'h01;
      if (apply_flip && (2*i+1) == 37) b = b ^ 8'h01;
      ca = 8'((ca << 1) | (ca >> 7)) ^ a;
      cb = 8'((cb << 1) | (cb >> 7)) ^ b;
    end
    return {cb, ca};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) tbl[i] = 8'($urandom);
  endtask

  // One load+verify run, starting from the current (post-negedge) instant.
  task automatic do_run(input bit stall, input int abort_beat, input bit pokes);
    int t, k, last_t, done_t, e_rdy, e_wr, e_busy, nd;
    bit beat;
    t = 0; k = 0; last_t = -1; done_t = -1; e_rdy = 0; e_wr = 0; e_busy = 0;
    start = 1'b1;
    in_valid = 1'b0;
    in_data = 16'($urandom);
    while (done_t < 0) begin
      @(negedge clk);
      t++;
      start = pokes && (t == 100 || t == 600);
      in_valid = stall ? ((t % 3) != 0) : 1'b1;
      if (k < 512) in_data = {tbl[2*k+1], tbl[2*k]};
      else         in_data = 16'($urandom);
      if (abort_beat >= 0 && k == abort_beat) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_wea", wea, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_checksum", checksum, 0);
        nd = 0;
        repeat (700) begin
          @(negedge clk);
          #1;
          if (done || busy) nd++;
        end
        chk("abort_no_done", nd, 0);
        return;
      end
      #1;
      beat = in_valid && in_ready;
      if (in_ready !== (k < 512)) e_rdy++;
      if (wea !== beat || web !== beat) e_wr++;
      if (beat && (addra != 10'(2*k) || addrb != 10'(2*k+1) ||
                   dia != tbl[2*k] || dib != tbl[2*k+1])) e_wr++;
      if (busy !== 1'b1) e_busy++;
      if (done === 1'b1) done_t = t;
      if (beat) begin
        k++;
        if (k == 512) last_t = t;
      end
      if (t > 4000) begin
        chk("timeout", 1, 0);
        return;
      end
    end
    chk("done_cycle", done_t, last_t + 515);
    if (!stall) chk("load_end", last_t, 512);
    chk("ready_errs", e_rdy, 0);
    chk("write_errs", e_wr, 0);
    chk("busy_errs", e_busy, 0);
    @(negedge clk);
    #1;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("checksum", checksum, model_cs(1'b0));
    chk("check_ok", check_ok, (model_cs(flip37) == model_cs(1'b0)));
  endtask

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ok", check_ok, 0);
    chk("rst_cs", checksum, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_en", en, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dia", dia, 0);
    rst = 1'b1;

    // All-zero table, ideal stream.
    for (int i = 0; i < 1024; i++) tbl[i] = 8'h00;
    do_run(1'b0, -1, 1'b0);
    chk("zero_cs", checksum, 16'h0000);

    // Ramp table with a stall every third cycle; check BRAM image.
    for (int i = 0; i < 1024; i++) tbl[i] = i[7:0];
    do_run(1'b1, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== tbl[i]) bad++;
    chk("mem_image", bad, 0);

    // Corrupted readback at address 37.
    fill_random();
    flip37 = 1'b1;
    do_run(1'b0, -1, 1'b0);
    flip37 = 1'b0;

    // Reset after 100 beats, then a clean full run.
    fill_random();
    do_run(1'b0, 100, 1'b0);
    fill_random();
    do_run(1'b0, -1, 1'b0);

    // Stray starts during LOAD and VERIFY.
    fill_random();
    do_run(1'b0, -1, 1'b1);

    // Back-to-back runs, second start the cycle after done.
    fill_random();
    do_run(1'b0, -1, 1'b0);
    fill_random();
    do_run(1'b1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sbox_bram_table_loader.md
Name: sbox_bram_table_loader

Overview:
- Runtime writer and verifier for the dual-port 8-bit masked S-box BRAM tables, which the datapath otherwise only reads.
- Streams a fresh table (for example, after a mask refresh) into the BRAM, two bytes per beat: port A takes the even address, port B the odd one.
- After the load, reads the whole table back through both registered read ports and compares a rolling checksum of the readback against the one accumulated while writing.
- Sits between the table-generation logic and the BRAM macro. The S-box datapath must be stalled while `busy` is high.

Parameters:
- DEPTH, 1024, number of byte entries in the BRAM; even power of two.
- ADDR_W, 10, BRAM address width; equals log2(DEPTH).
- RD_LAT, 2, BRAM read latency in cycles (output register enabled).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin load plus verify; sampled only in IDLE.
- in_data  in  16  table bytes; [7:0] goes to address 2k, [15:8] to address 2k+1.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- bram_addra  out  ADDR_W  port A address.
- bram_addrb  out  ADDR_W  port B address.
- bram_dia  out  8  port A write data.
- bram_dib  out  8  port B write data.
- bram_wea  out  1  port A write enable.
- bram_web  out  1  port B write enable.
- bram_en  out  1  ENA/ENB/REGCE enable for both ports.
- doa  in  8  port A read data.
- dob  in  8  port B read data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at completion.
- check_ok  out  1  result of the last verify; held until the next start.
- checksum  out  16  write-side checksum {csB, csA} of the last load.

Behaviour:
- Reset (rst=0 at an edge) takes effect on the next edge, including mid-operation:
  - state goes to IDLE; the pointer, issue counter and the valid pipe clear;
  - csA, csB, checksum, check_ok and done all become 0.
  - The combinational outputs follow from IDLE: in_ready=0, bram_wea=0, bram_web=0, bram_en=0, addresses 0, write data 0.
  - A partially written table is left as-is and no done pulse is produced.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE:
  - start=1 -> LOAD; clear the pointer (ADDR_W-1 bits, counts pairs), csA, csB, check_ok.
  - Otherwise stay in IDLE.
- LOAD:
  - in_ready=1 combinationally (the BRAM accepts one write per cycle, no back-pressure).
  - On a beat (in_valid & in_ready), in the same cycle:
    - bram_wea=bram_web=bram_en=1;
    - bram_addra={ptr,0}, bram_addrb={ptr,1};
    - bram_dia=in_data[7:0], bram_dib=in_data[15:8].
  - Registered on a beat:
    - csA <= rotl1(csA)^in_data[7:0];
    - csB <= rotl1(csB)^in_data[15:8];
    - ptr <= ptr+1.
  - No beat: write enables 0; ptr and checksums hold.
  - The beat with ptr=DEPTH/2-1 -> VERIFY; ptr wraps to 0; checksum <= {csB_next, csA_next}.
- VERIFY:
  - Issue one read pair per cycle for DEPTH/2 cycles: bram_en=1, write enables 0, addresses {ptr,0} and {ptr,1}; ptr increments.
  - A valid shift register of length RD_LAT marks which cycles carry returning data.
  - doa/dob are sampled exactly RD_LAT cycles after issue and folded into rA/rB with the same rotl1-XOR, in address order.
  - bram_en stays 1 until the last sample is taken.
  - After the last sample -> DONE.
- DONE:
  - done=1 for one cycle; check_ok <= ({rB,rA}=={csB,csA}); -> IDLE.
- Latency for DEPTH=1024 with in_valid held high: start at cycle 0, LOAD over cycles 1..512, VERIFY over cycles 513..1026 (512 issues plus 2), done at cycle 1027.
- A start outside IDLE is ignored. start and rst=0 in the same cycle: reset wins.
- in_data is ignored whenever in_ready=0.

Test Plan:
- All-zero table, in_valid always high, ideal BRAM model with latency 2 -> checksum=16'h0000, check_ok=1, done pulses exactly at cycle 1027, busy high over cycles 1..1026.
- Table byte[i]=i[7:0], with in_valid deasserted every third cycle -> every BRAM address holds its byte, checksum matches the bench model, check_ok=1, no write on any stall cycle.
- BRAM model flips bit 0 of address 37 on readback -> done pulses, check_ok=0, checksum still equals the write-side value.
- rst=0 asserted after 100 beats, then released, then a new start with a full table -> busy=0 and wea=0 the cycle after reset, no done pulse for the aborted run, second run gives check_ok=1.
- start pulsed during LOAD and during VERIFY -> no restart, ptr undisturbed, exactly one done pulse.
- Two back-to-back runs with different tables, start in the cycle after done -> second checksum reflects only the second table; check_ok reflects the second verify.
